multicycle_cu: RTL and testbench

Multi-cycle control unit for the MIPS-subset CPU (R-type, lw, sw, beq, j, addiu). It replaces the single-cycle opcode decoder with a Moore-style state machine. That machine sequences one shared ALU, one unified instruction/data memory, and the IR/MDR/A/B/ALUOut registers over 3–5 cycles per instruction. A ready handshake on the memory port allows wait states. The block sits between the instruction register opcode field and every datapath enable/mux select.

---
 rtl/multicycle_cu_if.sv | 30 +++
 rtl/multicycle_cu.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cu_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_cu_if
//  Description : Unified instruction/data memory port between the multi-cycle
//                control unit and the memory. The control unit is the master:
//                it issues the address select and the read/write requests, and
//                the memory answers with mem_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_cu_if;
    logic iord;        // address mux: 0 = PC, 1 = ALUOut
    logic mem_read;    // read request
    logic mem_write;   // write request
    logic mem_ready;   // memory completes the current access this cycle

    modport master (
        output iord,
        output mem_read,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  iord,
        input  mem_read,
        input  mem_write,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_cu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_cu
//  Description : Moore-style control unit for a multi-cycle MIPS subset
//                (R-type, lw, sw, beq, j, addiu). It sequences the shared ALU,
//                the unified memory and the IR/MDR/A/B/ALUOut registers over
//                3-5 cycles per instruction. The memory port has a ready
//                handshake that allows wait states. A watchdog flags long
//                waits, and a sticky flag records unsupported opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_cu #(
    parameter int WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_cu_if.master       mem,
    input  logic [5:0]            op_code,
    input  logic                  zero,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [1:0]            pc_source,
    output logic [3:0]            state,
    output logic                  illegal_op,
    output logic                  mem_timeout
);

    localparam int             CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] C_WAIT_MAX = CNT_W'(WAIT_MAX);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JMP      = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wdog;
    logic [CNT_W-1:0]   w_wdog_next;
    logic               w_waiting;
    logic               w_illegal_seen;
    logic               r_illegal;
    logic               r_timeout;

    logic               w_iord;
    logic               w_mem_read;
    logic               w_mem_write;

    // The zero flag gates pc_write_cond in the datapath, not in this block.
    logic               unused_zero;
    assign unused_zero = zero;

    // State register; an asserted reset abandons any partial instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs (FETCH write enables also follow mem_ready).
    always_comb begin
        w_next         = S_FETCH;
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        w_iord         = 1'b0;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        ir_write       = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        reg_write      = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        alu_op         = 2'b00;
        pc_source      = 2'b00;
        w_illegal_seen = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Reset forces state to FETCH; keep requests and loads quiet
                // while rst_n is low so nothing is written during reset.
                w_mem_read = rst_n;
                alu_src_b  = 2'b01;
                ir_write   = mem.mem_ready & rst_n;
                pc_write   = mem.mem_ready & rst_n;
                w_next     = mem.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op_code)
                    OP_RTYPE:      w_next = S_R_EX;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ:        w_next = S_BEQ;
                    OP_J:          w_next = S_JMP;
                    OP_ADDIU:      w_next = S_ADDI_EX;
                    default: begin
                        w_next         = S_FETCH;
                        w_illegal_seen = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                w_next     = mem.mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_next      = mem.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Watchdog: count consecutive stalled cycles in a memory state, saturating.
    always_comb begin
        w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR)) && !mem.mem_ready;
        w_wdog_next = '0;
        if (w_waiting) begin
            w_wdog_next = (r_wdog == C_WAIT_MAX) ? r_wdog : r_wdog + 1'b1;
        end
    end

    // Watchdog counter and sticky status flags; only reset clears the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog <= w_wdog_next;
            if (w_illegal_seen) begin
                r_illegal <= 1'b1;
            end
            if (w_waiting && (w_wdog_next == C_WAIT_MAX)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign mem.iord      = w_iord;
    assign mem.mem_read  = w_mem_read;
    assign mem.mem_write = w_mem_write;
    assign state         = r_state;
    assign illegal_op    = r_illegal;
    assign mem_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_cu
//  Description : Self-checking bench for multicycle_cu. Instructions are
//                described by type and wait-state counts. The expected state
//                sequence and control word for each cycle are derived from the
//                per-state control table and per-instruction state paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_cu;

    localparam int WAIT_MAX = 6;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

    logic       clk;
    logic       rst_n;
    logic [5:0] op_code;
    logic       zero;
    logic       pc_write, pc_write_cond, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;

    multicycle_cu_if bus();

    multicycle_cu #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem           (bus),
        .op_code       (op_code),
        .zero          (zero),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference status: sticky flags and the current stalled-cycle run length.
    bit m_illegal = 1'b0;
    bit m_timeout = 1'b0;
    int lowrun    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) ||
               (op == 6'h04) || (op == 6'h02) || (op == 6'h09);
    endfunction

    // Control word per state from the control table:
    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    function automatic logic [15:0] exp_ctrl(input int st, input bit rdy, input bit in_rst);
        bit       pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0;
        bit       rd = 0, m2r = 0, rw = 0, sa = 0;
        bit [1:0] sb = 0, aop = 0, ps = 0;
        case (st)
            0: begin mr = !in_rst; sb = 2'b01; irw = rdy && !in_rst; pw = rdy && !in_rst; end
            1: begin sb = 2'b11; end
            2: begin sa = 1; sb = 2'b10; end
            3: begin mr = 1; io = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; io = 1; end
            6: begin sa = 1; aop = 2'b10; end
            7: begin rw = 1; rd = 1; end
            8: begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            9: begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; end
            default: begin end
        endcase
        return {pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ps};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {pc_write, pc_write_cond, bus.iord, bus.mem_read, bus.mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    // One clock cycle: apply inputs, check outputs mid-cycle, then advance.
    task automatic step(input bit rdy, input logic [5:0] op, input int exp_st);
        bus.mem_ready = rdy;
        op_code       = op;
        zero          = 1'($urandom);
        #2;
        check($sformatf("state(exp %0d)", exp_st), 32'(state), exp_st);
        check($sformatf("ctrl(st %0d rdy %0d)", exp_st, rdy), 32'(obs_ctrl()),
              32'(exp_ctrl(exp_st, rdy, 1'b0)));
        check("illegal_op", 32'(illegal_op), 32'(m_illegal));
        check("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
        @(posedge clk);
        #1;
        if (exp_st == 1 && !legal(op)) m_illegal = 1'b1;
        if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !rdy) begin
            lowrun++;
            if (lowrun >= WAIT_MAX) m_timeout = 1'b1;
        end else begin
            lowrun = 0;
        end
    endtask

    function automatic logic [5:0] op_of(input int kind);
        logic [5:0] op;
        case (kind)
            K_R:    op = 6'h00;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2b;
            K_BEQ:  op = 6'h04;
            K_J:    op = 6'h02;
            K_ADDI: op = 6'h09;
            default: begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    // Whole instruction: wf FETCH wait cycles, wm wait cycles in the data access.
    task automatic run_instr(input int kind, input int wf, input int wm, input logic [5:0] op);
        for (int i = 0; i < wf; i++) step(1'b0, 6'($urandom), 0);
        step(1'b1, 6'($urandom), 0);
        step(1'($urandom), op, 1);
        case (kind)
            K_R: begin
                step(1'($urandom), 6'($urandom), 6);
                step(1'($urandom), 6'($urandom), 7);
            end
            K_LW: begin
                step(1'($urandom), op, 2);
                for (int i = 0; i < wm; i++) step(1'b0, 6'($urandom), 3);
                step(1'b1, 6'($urandom), 3);
                step(1'($urandom), 6'($urandom), 4);
            end
            K_SW: begin
                step(1'($urandom), op, 2);
                for (int i = 0; i < wm; i++) step(1'b0, 6'($urandom), 5);
                step(1'b1, 6'($urandom), 5);
            end
            K_BEQ:  step(1'($urandom), 6'($urandom), 8);
            K_J:    step(1'($urandom), 6'($urandom), 9);
            K_ADDI: begin
                step(1'($urandom), 6'($urandom), 10);
                step(1'($urandom), 6'($urandom), 11);
            end
            default: begin end
        endcase
    endtask

    initial begin
        int kind;
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        op_code       = 6'h00;
        zero          = 1'b0;

        // Reset state: FETCH selects, but no requests or loads despite mem_ready.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b1, 1'b1)));
        check("rst_illegal", 32'(illegal_op), 0);
        check("rst_timeout", 32'(mem_timeout), 0);
        rst_n = 1'b1;

        // Directed instruction paths.
        run_instr(K_R,    0, 0, op_of(K_R));
        run_instr(K_LW,   0, 2, op_of(K_LW));
        run_instr(K_SW,   1, 0, op_of(K_SW));
        run_instr(K_BEQ,  0, 0, op_of(K_BEQ));
        run_instr(K_J,    0, 0, op_of(K_J));
        run_instr(K_ADDI, 0, 0, op_of(K_ADDI));
        run_instr(K_ILL,  0, 0, 6'b111111);
        run_instr(K_R,    0, 0, op_of(K_R));

        // Watchdog: WAIT_MAX stalled FETCH cycles set the sticky timeout.
        for (int i = 0; i < WAIT_MAX; i++) step(1'b0, 6'($urandom), 0);
        run_instr(K_R, 0, 0, op_of(K_R));

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 6));
            run_instr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), op_of(kind));
        end

        // Reset pulsed in the middle of a stalled store.
        step(1'b1, 6'($urandom), 0);
        step(1'b1, 6'h2b, 1);
        step(1'b1, 6'h2b, 2);
        bus.mem_ready = 1'b0;
        #2;
        check("sw_wait_state", 32'(state), 5);
        check("sw_wait_mem_write", 32'(bus.mem_write), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 0);
        check("async_rst_mem_write", 32'(bus.mem_write), 0);
        check("async_rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b0, 1'b1)));
        check("async_rst_illegal", 32'(illegal_op), 0);
        check("async_rst_timeout", 32'(mem_timeout), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        lowrun    = 0;
        run_instr(K_LW, 1, 1, op_of(K_LW));
        run_instr(K_ILL, 0, 0, op_of(K_ILL));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
